alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_if.sv | 45 ++++
 rtl/alu_arbiter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter_if.sv
// ---------------------------------------------------------------------------
// alu_arbiter_if
//   Bundles the two requester ports, the shared-ALU connection and the
//   response bus of alu_arbiter.
//
//   Requester side : req0/op0/a0/b0, req1/op1/a1/b1
//   Shared ALU     : alu_op/alu_a/alu_b (to ALU), alu_res/alu_zero (from ALU)
//   Response       : done0, done1, res, zero, err, busy
//
//   slave  : the arbiter's view
//   master : the environment's view (both requesters plus the ALU)
// ---------------------------------------------------------------------------
interface alu_arbiter_if;
    logic        req0;
    logic [3:0]  op0;
    logic [31:0] a0;
    logic [31:0] b0;
    logic        req1;
    logic [3:0]  op1;
    logic [31:0] a1;
    logic [31:0] b1;

    logic [3:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_res;
    logic        alu_zero;

    logic        done0;
    logic        done1;
    logic [31:0] res;
    logic        zero;
    logic        err;
    logic        busy;

    modport slave (
        input  req0, op0, a0, b0, req1, op1, a1, b1, alu_res, alu_zero,
        output alu_op, alu_a, alu_b, done0, done1, res, zero, err, busy
    );

    modport master (
        output req0, op0, a0, b0, req1, op1, a1, b1, alu_res, alu_zero,
        input  alu_op, alu_a, alu_b, done0, done1, res, zero, err, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//   Shares one multi-cycle ALU between two requester ports. A request is
//   granted only from IDLE (round-robin on a tie), its op/operands are
//   latched, the ALU is driven for ALU_LAT cycles, and the result is
//   returned with a one-cycle done pulse on the granted port. Op codes
//   10..15 are rejected without touching the ALU.
//
//   Parameter ALU_LAT : ALU cycles per operation (1..15)
//   clk               : clock, rising edge
//   rst               : synchronous active-high reset
//   bus (slave)       : requester ports, ALU connection, response/busy
// ---------------------------------------------------------------------------
module alu_arbiter #(
    parameter int unsigned ALU_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    alu_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] LAT_M1  = 4'(ALU_LAT - 1);
    localparam logic [3:0] OP_IDLE = 4'hF;

    function automatic logic isAluOp(input logic [3:0] op);
        return op <= 4'd9;
    endfunction

    state_t      state, stateNext;
    logic [3:0]  cnt, cntNext;
    logic        last, lastNext;
    logic        portReg, portNext;
    logic [3:0]  opReg, opNext;
    logic [31:0] aReg, aNext;
    logic [31:0] bReg, bNext;
    logic [31:0] resReg, resNext;
    logic        zeroReg, zeroNext;
    logic        errReg, errNext;

    // Grant candidate: on a tie the port that did not win last time.
    logic        grantPort;
    logic [3:0]  selOp;
    logic [31:0] selA;
    logic [31:0] selB;

    assign grantPort = (bus.req0 && bus.req1) ? ~last : bus.req1;
    assign selOp     = grantPort ? bus.op1 : bus.op0;
    assign selA      = grantPort ? bus.a1  : bus.a0;
    assign selB      = grantPort ? bus.b1  : bus.b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            last    <= 1'b1;
            portReg <= 1'b0;
            opReg   <= 4'd0;
            aReg    <= 32'd0;
            bReg    <= 32'd0;
            resReg  <= 32'd0;
            zeroReg <= 1'b0;
            errReg  <= 1'b0;
        end else begin
            state   <= stateNext;
            cnt     <= cntNext;
            last    <= lastNext;
            portReg <= portNext;
            opReg   <= opNext;
            aReg    <= aNext;
            bReg    <= bNext;
            resReg  <= resNext;
            zeroReg <= zeroNext;
            errReg  <= errNext;
        end
    end

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        lastNext  = last;
        portNext  = portReg;
        opNext    = opReg;
        aNext     = aReg;
        bNext     = bReg;
        resNext   = resReg;
        zeroNext  = zeroReg;
        errNext   = errReg;

        unique case (state)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    portNext = grantPort;
                    lastNext = grantPort;
                    opNext   = selOp;
                    aNext    = selA;
                    bNext    = selB;
                    if (isAluOp(selOp)) begin
                        stateNext = EXEC;
                        cntNext   = LAT_M1;
                    end else begin
                        // Rejected op: answer immediately, ALU stays idle.
                        stateNext = RESP;
                        cntNext   = 4'd0;
                        resNext   = 32'd0;
                        zeroNext  = 1'b0;
                        errNext   = 1'b1;
                    end
                end
            end
            EXEC: begin
                if (cnt == 4'd0) begin
                    stateNext = RESP;
                    resNext   = bus.alu_res;
                    zeroNext  = bus.alu_zero;
                    errNext   = 1'b0;
                end else begin
                    cntNext = cnt - 4'd1;
                end
            end
            RESP: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Outputs decode registered state only; the response bus is forced to
    // zero outside RESP so consumers never see stale results.
    always_comb begin
        bus.alu_op = OP_IDLE;
        bus.alu_a  = 32'd0;
        bus.alu_b  = 32'd0;
        bus.done0  = 1'b0;
        bus.done1  = 1'b0;
        bus.res    = 32'd0;
        bus.zero   = 1'b0;
        bus.err    = 1'b0;
        bus.busy   = (state != IDLE);
        if (state == EXEC) begin
            bus.alu_op = opReg;
            bus.alu_a  = aReg;
            bus.alu_b  = bReg;
        end
        if (state == RESP) begin
            bus.done0 = ~portReg;
            bus.done1 = portReg;
            bus.res   = resReg;
            bus.zero  = zeroReg;
            bus.err   = errReg;
        end
    end

endmodule
